// File: rtl/layout_pkg.sv
// Shared definitions for the layout streamer: default sizes plus the FSM and mode enums.
package layout_pkg;

  localparam int BITS_DEF = 8;
  localparam int DIM_DEF  = 32;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_e;
  typedef enum logic {MODE_ROW, MODE_COL} mode_e;

endpackage

// File: rtl/layout_skew_sel.sv
// Per-lane diagonal selector: maps beat t to the buffer (row, col) this lane shows and whether it is in range.
module layout_skew_sel
  import layout_pkg::*;
#(
  parameter int DIM  = DIM_DEF,
  parameter int LANE = 0
) (
  input  logic [$clog2(2*DIM):0]  t,
  input  logic [$clog2(DIM):0]    m,
  input  logic [$clog2(DIM):0]    n,
  input  mode_e                   mode,
  output logic [$clog2(DIM)-1:0]  row,
  output logic [$clog2(DIM)-1:0]  col,
  output logic                    hit
);

  localparam int TW = $clog2(2*DIM) + 1;
  localparam int IW = $clog2(DIM);

  logic [TW-1:0] lane;
  logic [TW-1:0] diff;
  logic [TW-1:0] m_w;
  logic [TW-1:0] n_w;
  logic          started;

  // diff is only trusted once t has reached this lane, so t-lane can never wrap into range
  always_comb begin
    lane    = TW'(LANE);
    m_w     = TW'(m);
    n_w     = TW'(n);
    started = (t >= lane);
    diff    = t - lane;
    row     = '0;
    col     = '0;
    hit     = 1'b0;
    if (mode == MODE_ROW) begin
      row = IW'(lane);
      col = IW'(diff);
      hit = (lane < m_w) && started && (diff < n_w);
    end else begin
      row = IW'(diff);
      col = IW'(lane);
      hit = (lane < n_w) && started && (diff < m_w);
    end
  end

endmodule

// File: rtl/layout_stream.sv
// Loads an m x n tile row by row, then streams it as a skewed wavefront (row- or column-skew) of m+n-1 beats.
module layout_stream
  import layout_pkg::*;
#(
  parameter int BITS = BITS_DEF,
  parameter int DIM  = DIM_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [$clog2(DIM):0]   cfg_m,
  input  logic [$clog2(DIM):0]   cfg_n,
  input  logic                   cfg_mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DIM*BITS-1:0]    in_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIM*BITS-1:0]    out_vec,
  output logic [DIM-1:0]         out_mask,
  output logic                   done,
  output logic                   err
);

  localparam int CW = $clog2(DIM) + 1;
  localparam int TW = $clog2(2*DIM) + 1;
  localparam int IW = $clog2(DIM);

  state_e          state;
  state_e          state_nxt;
  logic [CW-1:0]   m_q;
  logic [CW-1:0]   n_q;
  mode_e           mode_q;
  logic [TW-1:0]   r_q;
  logic [TW-1:0]   t_q;
  logic            cfg_ok;
  logic            last_row;
  logic            last_beat;
  logic            streaming;

  logic [BITS-1:0] mem [DIM][DIM];
  logic [IW-1:0]   sel_row [DIM];
  logic [IW-1:0]   sel_col [DIM];
  logic [DIM-1:0]  sel_hit;

  assign cfg_ok    = (cfg_m != '0) && (cfg_m <= CW'(DIM)) && (cfg_n != '0) && (cfg_n <= CW'(DIM));
  assign last_row  = (r_q == TW'(m_q) - TW'(1));
  assign last_beat = (t_q == TW'(m_q) + TW'(n_q) - TW'(2));
  assign streaming = (state == STREAM);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start && cfg_ok) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_row) state_nxt = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        if (out_ready && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // done and err are registered so each is a clean one-cycle pulse after the triggering edge
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q    <= '0;
      n_q    <= '0;
      mode_q <= MODE_ROW;
      r_q    <= '0;
      t_q    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && cfg_ok) begin
            m_q    <= cfg_m;
            n_q    <= cfg_n;
            mode_q <= mode_e'(cfg_mode);
            r_q    <= '0;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        LOAD: begin
          if (in_valid) begin
            r_q <= r_q + TW'(1);
            if (last_row) t_q <= '0;
          end
        end
        STREAM: begin
          if (out_ready) begin
            t_q <= t_q + TW'(1);
            if (last_beat) done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tile storage needs no reset: nothing reaches out_vec unless its lane is masked in
  always_ff @(posedge clk) begin
    if (!rst && state == LOAD && in_valid) begin
      for (int j = 0; j < DIM; j++) mem[r_q[IW-1:0]][j] <= in_row[j*BITS +: BITS];
    end
  end

  for (genvar k = 0; k < DIM; k++) begin : g_lane
    layout_skew_sel #(.DIM(DIM), .LANE(k)) u_sel (
      .t    (t_q),
      .m    (m_q),
      .n    (n_q),
      .mode (mode_q),
      .row  (sel_row[k]),
      .col  (sel_col[k]),
      .hit  (sel_hit[k])
    );
    assign out_mask[k]             = streaming && sel_hit[k];
    assign out_vec[k*BITS +: BITS] = out_mask[k] ? mem[sel_row[k]][sel_col[k]] : '0;
  end

endmodule

// File: tb/tb_layout_stream.sv
// Directed bench for layout_stream: hand-computed 3x3 beat table plus stall, error, reset and full-size sequences.
module tb_layout_stream;

  localparam int BITS = 8;
  localparam int DIM  = 32;
  localparam int CW   = $clog2(DIM) + 1;
  localparam int VW   = DIM * BITS;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] cfg_m;
  logic [CW-1:0] cfg_n;
  logic          cfg_mode;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_row;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_vec;
  logic [DIM-1:0] out_mask;
  logic          done;
  logic          err;

  layout_stream #(.BITS(BITS), .DIM(DIM)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_m     (cfg_m),
    .cfg_n     (cfg_n),
    .cfg_mode  (cfg_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_mask  (out_mask),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  logic [BITS-1:0] data [DIM][DIM];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit              mode;
    logic [BITS-1:0] l0;
    logic [BITS-1:0] l1;
    logic [BITS-1:0] l2;
    logic [2:0]      mask;
  } beat_t;

  beat_t tbl [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference skew model, written straight from the wavefront definition
  function automatic logic [VW-1:0] exp_vec(input int m, input int n, input int mode, input int t);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < DIM; k++) begin
      if (mode == 0) begin
        if (k < m && t - k >= 0 && t - k < n) v[k*BITS +: BITS] = data[k][t-k];
      end else begin
        if (k < n && t - k >= 0 && t - k < m) v[k*BITS +: BITS] = data[t-k][k];
      end
    end
    return v;
  endfunction

  function automatic logic [DIM-1:0] exp_mask(input int m, input int n, input int mode, input int t);
    logic [DIM-1:0] v;
    v = '0;
    for (int k = 0; k < DIM; k++) begin
      if (mode == 0) v[k] = (k < m && t - k >= 0 && t - k < n);
      else           v[k] = (k < n && t - k >= 0 && t - k < m);
    end
    return v;
  endfunction

  task automatic applyStimulus(input int m, input int n, input int mode);
    start    = 1'b1;
    cfg_m    = CW'(m);
    cfg_n    = CW'(n);
    cfg_mode = (mode != 0);
    tick();
    start = 1'b0;
    checkOutput("in_ready_load", VW'(in_ready), VW'(1));
    for (int r = 0; r < m; r++) begin
      for (int j = 0; j < DIM; j++) in_row[j*BITS +: BITS] = data[r][j];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checkOutput("out_valid_stream", VW'(out_valid), VW'(1));
  endtask

  task automatic streamCheck(input int m, input int n, input int mode, input bit stall, input string tag);
    int            t   = 0;
    int            cyc = 0;
    bit            held = 1'b0;
    logic [VW-1:0] prev;
    prev = '0;
    while (t < m + n - 1 && cyc < 4 * (m + n) + 20) begin
      if (held) checkOutput({tag, "_hold"}, out_vec, prev);
      checkOutput({tag, "_vec"}, out_vec, exp_vec(m, n, mode, t));
      checkOutput({tag, "_mask"}, VW'(out_mask), VW'(exp_mask(m, n, mode, t)));
      out_ready = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      held = out_valid && !out_ready;
      prev = out_vec;
      if (out_valid && out_ready) t++;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    checkOutput({tag, "_beats"}, VW'(t), VW'(m + n - 1));
    checkOutput({tag, "_done"}, VW'(done), VW'(1));
    checkOutput({tag, "_idle"}, VW'(out_valid), VW'(0));
    tick();
    checkOutput({tag, "_done_clear"}, VW'(done), VW'(0));
  endtask

  task automatic randomData();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) data[r][c] = BITS'($urandom);
  endtask

  initial begin
    logic [VW-1:0] exp;

    rst = 1'b1; start = 1'b0; cfg_m = '0; cfg_n = '0; cfg_mode = 1'b0;
    in_valid = 1'b0; in_row = '0; out_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst_in_ready", VW'(in_ready), VW'(0));
    checkOutput("rst_out_valid", VW'(out_valid), VW'(0));
    checkOutput("rst_done", VW'(done), VW'(0));
    checkOutput("rst_err", VW'(err), VW'(0));
    checkOutput("rst_mask", VW'(out_mask), VW'(0));
    checkOutput("rst_vec", out_vec, '0);
    rst = 1'b0;
    tick();

    // 3x3 tile 1..9; lanes beyond n carry junk that must never appear
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) data[r][c] = 8'hEE;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) data[r][c] = BITS'(r * 3 + c + 1);

    tbl[0] = '{1'b0, 8'd1, 8'd0, 8'd0, 3'b001};
    tbl[1] = '{1'b0, 8'd2, 8'd4, 8'd0, 3'b011};
    tbl[2] = '{1'b0, 8'd3, 8'd5, 8'd7, 3'b111};
    tbl[3] = '{1'b0, 8'd0, 8'd6, 8'd8, 3'b110};
    tbl[4] = '{1'b0, 8'd0, 8'd0, 8'd9, 3'b100};
    tbl[5] = '{1'b1, 8'd1, 8'd0, 8'd0, 3'b001};
    tbl[6] = '{1'b1, 8'd4, 8'd2, 8'd0, 3'b011};
    tbl[7] = '{1'b1, 8'd7, 8'd5, 8'd3, 3'b111};
    tbl[8] = '{1'b1, 8'd0, 8'd8, 8'd6, 3'b110};
    tbl[9] = '{1'b1, 8'd0, 8'd0, 8'd9, 3'b100};

    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 0) begin
        applyStimulus(3, 3, int'(tbl[i].mode));
        out_ready = 1'b1;
      end
      exp = '0;
      exp[7:0]   = tbl[i].l0;
      exp[15:8]  = tbl[i].l1;
      exp[23:16] = tbl[i].l2;
      checkOutput($sformatf("tbl%0d_vec", i), out_vec, exp);
      checkOutput($sformatf("tbl%0d_mask", i), VW'(out_mask), VW'(tbl[i].mask));
      tick();
      if (i % 5 == 4) begin
        checkOutput($sformatf("tbl%0d_done", i), VW'(done), VW'(1));
        out_ready = 1'b0;
        tick();
      end
    end

    // Bad configs: zero rows, then too many columns
    start = 1'b1; cfg_m = '0; cfg_n = CW'(3);
    tick();
    start = 1'b0;
    checkOutput("err_m0", VW'(err), VW'(1));
    checkOutput("err_m0_ready", VW'(in_ready), VW'(0));
    tick();
    checkOutput("err_m0_clear", VW'(err), VW'(0));
    start = 1'b1; cfg_m = CW'(3); cfg_n = CW'(DIM + 1);
    tick();
    start = 1'b0;
    checkOutput("err_nbig", VW'(err), VW'(1));
    checkOutput("err_nbig_ready", VW'(in_ready), VW'(0));
    checkOutput("err_nbig_valid", VW'(out_valid), VW'(0));
    tick();

    // 2x4 with back-pressure; a stray start mid-job must be ignored
    randomData();
    applyStimulus(2, 4, 0);
    start = 1'b1; cfg_m = '0;
    tick();
    start = 1'b0;
    checkOutput("ignored_start_err", VW'(err), VW'(0));
    checkOutput("ignored_start_valid", VW'(out_valid), VW'(1));
    streamCheck(2, 4, 0, 1'b1, "stall");

    // Abort a 14x14 job on beat 2, then run a fresh 5x5 job
    randomData();
    applyStimulus(14, 14, 0);
    out_ready = 1'b1;
    tick();
    tick();
    checkOutput("abort_beat2", out_vec, exp_vec(14, 14, 0, 2));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    checkOutput("abort_valid", VW'(out_valid), VW'(0));
    checkOutput("abort_ready", VW'(in_ready), VW'(0));
    checkOutput("abort_vec", out_vec, '0);
    checkOutput("abort_mask", VW'(out_mask), VW'(0));
    checkOutput("abort_done", VW'(done), VW'(0));
    tick();
    checkOutput("abort_done_later", VW'(done), VW'(0));
    applyStimulus(5, 5, 1);
    streamCheck(5, 5, 1, 1'b0, "fresh5");

    // Full-size tiles both modes, then the 1x1 corner
    randomData();
    applyStimulus(DIM, DIM, 0);
    streamCheck(DIM, DIM, 0, 1'b0, "full_row");
    applyStimulus(DIM, DIM, 1);
    streamCheck(DIM, DIM, 1, 1'b1, "full_col");
    applyStimulus(1, 1, 0);
    streamCheck(1, 1, 0, 1'b0, "single");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layout_stream.md
LAYOUT_STREAM -- requirements
Module: layout_stream

Interface
REQ-001 The block SHALL have parameter BITS, default 8, meaning bit width of one pixel.
REQ-002 The block SHALL have parameter DIM, default 32, meaning maximum feature-map dimension and output lane count.
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port start  input  1  one-cycle request to begin a job, sampled in IDLE only.
REQ-006 The block SHALL have port cfg_m  input  $clog2(DIM)+1  row count m, captured on accepted start.
REQ-007 The block SHALL have port cfg_n  input  $clog2(DIM)+1  column count n, captured on accepted start.
REQ-008 The block SHALL have port cfg_mode  input  1  layout mode, captured on accepted start: 0 = row-skew (A operand), 1 = column-skew (B operand).
REQ-009 The block SHALL have ports in_valid, in_ready, and in_row  input/output/input  1/1/DIM*BITS  row-load handshake; lane j is in_row[j].
REQ-010 The block SHALL have ports out_valid, out_ready, out_vec, and out_mask  output/input/output/output  1/1/DIM*BITS/DIM  skewed wavefront stream.
REQ-011 The block SHALL have ports done and err  output/output  1/1  one-cycle completion and config-error pulses.

Function
REQ-012 The block SHALL have states IDLE, LOAD, and STREAM.
- IDLE: in_ready=0, out_valid=0.
REQ-013 In IDLE, a start with 1<=cfg_m<=DIM and 1<=cfg_n<=DIM SHALL capture the config, clear the row counter, and enter LOAD next cycle.
REQ-014 In IDLE, a start with cfg_m or cfg_n equal to 0 or greater than DIM SHALL pulse err for one cycle and stay in IDLE.
REQ-015 In LOAD, in_ready SHALL be 1, and each in_valid&&in_ready SHALL write in_row to buffer row r, then increment r.
REQ-016 Lanes j>=n of a loaded row SHALL be stored but never emitted.
REQ-017 After the row with r=m-1 is accepted, the block SHALL enter STREAM next cycle with beat counter t=0.
REQ-018 In STREAM, out_valid SHALL be 1, and the beat count SHALL be exactly m+n-1 (t=0..m+n-2).
REQ-019 In mode 0, beat t, lane i SHALL carry A[i][t-i], with out_mask[i]=1, when i<m and 0<=t-i<n; otherwise the lane data and mask SHALL be 0.
REQ-020 In mode 1, beat t, lane j SHALL carry A[t-j][j], with out_mask[j]=1, when j<n and 0<=t-j<m; otherwise the lane data and mask SHALL be 0.
REQ-021 t SHALL advance only on out_valid&&out_ready; out_vec and out_mask SHALL stay stable while out_valid&&!out_ready.
REQ-022 On the accepted beat t=m+n-2, the block SHALL return to IDLE next cycle, with done=1 for exactly that one cycle.
REQ-023 A start outside IDLE SHALL be ignored, with no err.
- cfg_* SHALL be ignored outside IDLE.
REQ-024 The block SHALL introduce no combinational path from out_ready to out_vec.
REQ-025 The first beat SHALL be visible the cycle after STREAM entry at the latest.
REQ-026 Index arithmetic SHALL use signed or guarded comparisons so t-i never wraps into a valid index.
- Counters SHALL be $clog2(2*DIM)+1 bits wide.
REQ-027 m=n=1 SHALL yield exactly one beat, with lane 0 valid only.
REQ-028 m=n=DIM SHALL yield 2*DIM-1 beats.

Reset
REQ-029 On rst=1, the block SHALL set state IDLE.
- in_ready, out_valid, done, err, and out_mask SHALL be 0; out_vec SHALL be 0.
- Counters and captured config SHALL be 0.
REQ-030 Reset mid-LOAD or mid-STREAM SHALL abort the job with no done pulse.
- Buffer contents SHALL be don't-care after reset, never emitted unmasked.
REQ-031 The buffer array SHALL need no reset.

Structure
REQ-032 Package layout_pkg SHALL hold BITS and DIM defaults, the state enum (IDLE, LOAD, STREAM), and the mode enum (MODE_ROW, MODE_COL).
REQ-033 Per-lane diagonal selection (index, in-range mask) SHALL be one sub-module, layout_skew_sel, instantiated DIM times.
REQ-034 The buffer SHALL be DIM x DIM x BITS flops, fully read-addressable per lane.

Verification
REQ-035 Scenario: m=n=3, mode 0, rows {1,2,3},{4,5,6},{7,8,9}, out_ready=1 -> 5 beats: lanes(0..2) {1,0,0},{2,4,0},{3,5,7},{0,6,8},{0,0,9}; masks {100},{110},{111},{011},{001} (lane0 first); done on the cycle after beat 4.
REQ-036 Scenario: same data, mode 1 -> beats {1,0,0},{4,2,0},{7,5,3},{0,8,6},{0,0,9}.
REQ-037 Scenario: m=2, n=4 mode 0, out_ready toggled 1,0,0,1,... -> out_vec held during stalls; exactly 5 accepted beats; no duplicates or skips.
REQ-038 Scenario: start with cfg_m=0 or cfg_n=DIM+1 -> err pulse one cycle, state IDLE, in_ready=0.
REQ-039 Scenario: rst asserted on beat 2 of an m=n=14 job -> next cycle all outputs 0, IDLE, no done; a fresh m=n=5 job completes in 9 beats.
REQ-040 Scenario: m=n=DIM with random data -> 2*DIM-1 beats matching the scoreboard skew model; m=n=1 -> a single beat.
